// File: rtl/bfp_pkg.sv
// Shared types and constants for the block-floating-point slice sequencer.
package bfp_pkg;

   function automatic int calc_ew(input int bit_w, input int fpm);
      return bit_w - fpm - 1;
   endfunction

   localparam int DEF_BIT = 16;
   localparam int DEF_FPM = 10;
   localparam int EW      = calc_ew(DEF_BIT, DEF_FPM);

   typedef logic [EW-1:0] exp_t;

   localparam exp_t EXP_SPECIAL = '1;

   typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DRAIN} seq_state_t;

endpackage

// File: rtl/bfp_slice_sequencer_max_exp_p.sv
// Combinational P-lane unsigned exponent maximum with an Inf/NaN (all-ones) flag.
module max_exp_p
   import bfp_pkg::*;
#(
   parameter int P  = 4,
   parameter int EW = bfp_pkg::EW
) (
   input  logic [P-1:0][EW-1:0] i_exp,
   output logic [EW-1:0]        o_max,
   output logic                 o_special
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      o_max     = '0;
      o_special = 1'b0;
      for (int j = 0; j < P; j++) begin
         if (i_exp[j] > o_max) o_max = i_exp[j];
         if (i_exp[j] == '1)   o_special = 1'b1;
      end
   end

endmodule

// File: rtl/bfp_slice_sequencer.sv
// Sequences one BFP conversion: capture, P-lane exponent scan, slice issue, result drain.
module bfp_slice_sequencer
   import bfp_pkg::*;
#(
   parameter int V   = 16,
   parameter int P   = 4,
   parameter int BIT = 16,
   parameter int FPM = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [V-1:0][BIT-1:0]         vect,
   output logic                          slice_valid,
   input  logic                          slice_ready,
   output logic [$clog2(V)-1:0]          slice_idx,
   output logic [calc_ew(BIT,FPM)-1:0]   shared_exp,
   input  logic                          res_valid,
   output logic                          busy,
   output logic                          done,
   output logic                          exc,
   output logic                          err
);

   localparam int LEW = calc_ew(BIT, FPM);
   localparam int CW  = $clog2(V);
   localparam int OW  = $clog2(V/P + 1);

   localparam logic [CW-1:0] LAST_IDX = CW'(V - P);
   localparam logic [CW-1:0] STEP     = CW'(P);

   seq_state_t               r_state;
   seq_state_t               w_next;
   logic [V-1:0][BIT-1:0]    r_vect;
   logic [CW-1:0]            r_cnt;
   logic [LEW-1:0]           r_max;
   logic [OW-1:0]            r_outst;
   logic                     r_exc;
   logic                     r_err;

   logic                     w_accept;
   logic                     w_issue;
   logic                     w_last;
   logic [P-1:0][LEW-1:0]    w_lane_exp;
   logic [LEW-1:0]           w_scan_max;
   logic                     w_scan_special;

   assign w_accept = (r_state == IDLE) && in_valid;
   assign w_issue  = (r_state == ISSUE) && slice_ready;
   assign w_last   = (r_cnt == LAST_IDX);

   // The captured vector shifts down one slice per scan cycle, so lanes 0..P-1 are always current.
   always_comb begin
      w_lane_exp = '0;
      for (int j = 0; j < P; j++) w_lane_exp[j] = r_vect[j][FPM +: LEW];
   end

   max_exp_p #(.P(P), .EW(LEW)) u_max_exp (
      .i_exp     (w_lane_exp),
      .o_max     (w_scan_max),
      .o_special (w_scan_special)
   );

   // NOTE: sequential state uses non-blocking assignments so every register updates together.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)             w_next = SCAN;
         SCAN:    if (w_last)               w_next = ISSUE;
         ISSUE:   if (slice_ready && w_last) w_next = DRAIN;
         DRAIN:   if (r_outst == '0)        w_next = IDLE;
         default:                           w_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (r_state == IDLE);
      slice_valid = (r_state == ISSUE);
      busy        = (r_state != IDLE);
      done        = (r_state == DRAIN) && (r_outst == '0);
   end

   assign slice_idx  = r_cnt;
   assign shared_exp = r_max;
   assign exc        = r_exc;
   assign err        = r_err;

   // NOTE: the vector register is pure data loaded on accept, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_accept)              r_vect <= vect;
      else if (r_state == SCAN)  r_vect <= r_vect >> (P*BIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_max <= '0;
         r_exc <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_cnt <= '0;
               r_max <= '0;
               r_exc <= 1'b0;
            end
            SCAN: begin
               if (w_scan_max > r_max) r_max <= w_scan_max;
               if (w_scan_special)     r_exc <= 1'b1;
               r_cnt <= w_last ? '0 : r_cnt + STEP;
            end
            ISSUE: if (slice_ready) r_cnt <= w_last ? '0 : r_cnt + STEP;
            default: ;
         endcase
      end
   end

   // A stray result with nothing outstanding flags err and leaves the counter at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_outst <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) r_err <= 1'b0;
         case ({w_issue, res_valid})
            2'b10: r_outst <= r_outst + OW'(1);
            2'b01: begin
               if (r_outst != '0) r_outst <= r_outst - OW'(1);
               else               r_err   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/bfp_slice_sequencer.md
# bfp_slice_sequencer

Controller that sequences one block-floating-point conversion of a V-element FP vector. It captures the vector, scans it P lanes per cycle to find the shared (maximum) exponent, then issues V/P slice commands (start index plus shared exponent) to the P-lane mantissa-adjust datapath. It tracks outstanding slices until every result has returned, then pulses `done`. It sits between the operand source and the mantissa adjuster in the dot-product pipeline.

## Interface
Parameters:
- `V`, default 16: elements per vector; must be a multiple of `P`, with `V/P >= 1`.
- `P`, default 4: lanes per slice and per scan cycle.
- `BIT`, default 16: FP word width (sign, exponent, mantissa).
- `FPM`, default 10: stored mantissa bits; exponent width is `EW = BIT-FPM-1`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous active-high reset.
- `in_valid`  in  1  vector available on `vect`.
- `in_ready`  out  1  block idle and accepting.
- `vect`  in  `[V-1:0][BIT-1:0]`  operand vector; sampled only on accept.
- `slice_valid`  out  1  slice command valid.
- `slice_ready`  in  1  adjuster accepts command.
- `slice_idx`  out  `$clog2(V)`  first element index of the slice.
- `shared_exp`  out  `EW`  block exponent (scan maximum).
- `res_valid`  in  1  adjuster returned one slice result.
- `busy`  out  1  not IDLE.
- `done`  out  1  one-cycle pulse: all slices issued and returned.
- `exc`  out  1  sticky: an element had an all-ones exponent (Inf/NaN).
- `err`  out  1  sticky: `res_valid` arrived with zero outstanding.

## Operation
- States: IDLE → SCAN → ISSUE → DRAIN → IDLE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid && in_ready`: register `vect`, clear `cnt`, `max`, `exc`, `err`, go to SCAN.
- **SCAN**
  - Each cycle, take the max of `max` and the exponents of elements `cnt..cnt+P-1`, then `cnt += P`.
  - Set `exc` if any scanned exponent is `2^EW-1`.
  - After the slice at `cnt = V-P`: clear `cnt`, go to ISSUE.
- **ISSUE**
  - `slice_valid=1`, `slice_idx=cnt`, `shared_exp=max`.
  - On handshake: `cnt += P` and increment `outst`.
  - The handshake at `cnt = V-P` goes to DRAIN.
  - `slice_idx` and `shared_exp` hold stable while `slice_valid && !slice_ready`.
- **DRAIN**
  - Wait for `outst == 0`, then assert `done` for exactly one cycle and return to IDLE.
- Outstanding counter `outst`:
  - Width `$clog2(V/P+1)`; maximum value `V/P`.
  - Decrements on `res_valid` in any state.
  - Issue handshake and `res_valid` in the same cycle: net unchanged.
- `res_valid` with `outst == 0` and no same-cycle issue: set `err`, counter stays 0 (no underflow).
- Exponent `0` (zero/denormal) takes part in the max normally. All-zero vector gives `shared_exp = 0`.
- `exc` and `err` hold until the next accept or reset.

## Timing
- Reset values: `in_ready=1`, `slice_valid=0`, `slice_idx=0`, `shared_exp=0`, `busy=0`, `done=0`, `exc=0`, `err=0`. Internal `cnt`, `max`, `outst` = 0, state IDLE.
- Reset in any state aborts the operation immediately. Results still in flight in the adjuster are the adjuster's reset responsibility.
- Accept at edge 0: `in_ready` low from cycle 1.
- SCAN occupies cycles 1..V/P; first `slice_valid` appears in cycle `V/P+1`.
- With `slice_ready` tied high, the last issue is in cycle `2V/P`.
- `done` asserts in the cycle after `outst` becomes 0 in DRAIN.
  - If the last result returns in the same cycle as the last issue, `outst` still holds 1; `done` follows the later return.
- `in_ready` reasserts in the cycle after `done`. Back-to-back vectors are separated by at least one idle cycle.
- No combinational path from `slice_ready` or `res_valid` to any output.

## Structure
- Shared package `bfp_pkg`:
  - `EW` derivation function.
  - State enum `seq_state_t` {IDLE, SCAN, ISSUE, DRAIN}.
  - `exp_t` typedef.
  - Constant `EXP_SPECIAL = '1`.
- One sub-module `max_exp_p`: combinational P-input unsigned max over `exp_t` plus an any-all-ones flag. Instantiated once for the SCAN datapath.

## Test plan
Use V=8, P=4, BIT=16, FPM=10 unless noted.
- **Basic max:** exponents {3,7,1,0,5,2,6,4}, `slice_ready=1`, each result returned 2 cycles after issue → `shared_exp=7`; `slice_idx` 0 then 4 in cycles 3 and 4; `done` pulse in cycle 7; `exc=0`, `err=0`.
- **Backpressure:** `slice_ready` low for 3 cycles at the first command → `slice_idx=0` and `shared_exp` stable throughout; exactly 2 handshakes; `done` only after both results.
- **Exception and zero:** element 5 exponent 31 → `exc=1` and `shared_exp=31`. All-zero vector → `shared_exp=0`, `exc=0`.
- **Protocol error:** `res_valid` pulse while IDLE → `err=1`, `outst` stays 0. Next accept clears `err`.
- **Simultaneous events:** return of slice 0 in the same cycle as issue of slice 1 → `outst` stays 1; single `done` after the final return.
- **Reset mid-operation:** reset during ISSUE after one handshake → next cycle all outputs at reset values; a new vector then completes normally. With V=16, P=4, the 4 slices are issued at indices 0, 4, 8, 12.
